key_debounce: RTL
=================

Name: key_debounce

Overview:
- Input-side counterpart of the board LED chaser: conditions raw push-button inputs into clean levels and single-cycle press/release pulses.
- Maintains a 3-bit position index stepped by two of the keys; the index can drive an LED/one-hot display.
- Sits between the board pins and the display/control logic.
- Uses the same free-running-prescaler style as the LED chaser, but all logic runs on iCLK with a clock-enable tick.

Parameters:
- N_KEYS, 4, number of key inputs (≥2); key 0 = increment, key 1 = decrement.
- DIV_W, 19, prescaler width; one sample tick per 2^DIV_W clocks.
- STABLE_CNT, 4, consecutive differing ticks required to accept a new key level (≥2).

Ports:
- iCLK  input  1  system clock; all logic on rising edge.
- iRST_N  input  1  synchronous active-low reset, sampled on rising edge of iCLK.
- iKEY  input  N_KEYS  raw asynchronous keys; 1 = pressed.
- oKEY  output  N_KEYS  debounced key levels.
- oPRESS  output  N_KEYS  one-cycle pulse on each debounced 0->1 transition.
- oRELEASE  output  N_KEYS  one-cycle pulse on each debounced 1->0 transition.
- oPOS  output  3  position index, modulo 8.
- oTICK  output  1  sample-tick strobe, for debug and verification.

Behaviour:
- Reset (iRST_N=0 at a clock edge): all of the following clear to 0 on that edge, regardless of any in-progress debounce or prescale: synchronizer flops, prescaler, per-key counters, oKEY, oPRESS, oRELEASE, oPOS, oTICK.
- Synchronizer: two flops per key; a change on iKEY is visible to the debounce logic 2 cycles later.
- Prescaler: DIV_W-bit counter, +1 every clock, wraps naturally. oTICK=1 for exactly one cycle when the counter equals all-ones, i.e. one cycle every 2^DIV_W cycles. The first tick after reset occurs on cycle 2^DIV_W.
- Per-key debounce, evaluated only in tick cycles:
  - Synced value == oKEY[k]: clear counter[k].
  - Synced value != oKEY[k] and counter[k] == STABLE_CNT-1: toggle oKEY[k] and clear counter[k].
  - Otherwise: counter[k] +1.
  - Non-tick cycles: counter and oKEY hold.
  - Net effect: a level is accepted after STABLE_CNT consecutive ticks that all disagree with oKEY. Any agreeing tick restarts the count, so bounces shorter than that are rejected.
- Latency: from a stable iKEY change to the oKEY change is at least 2+(STABLE_CNT-1)·2^DIV_W and at most 2+STABLE_CNT·2^DIV_W+1 cycles.
- Pulses:
  - oPRESS[k] and oRELEASE[k] are registered on the same edge that updates oKEY[k].
  - Each is high for exactly one cycle, coincident with the first cycle of the new oKEY level.
  - oPRESS and oRELEASE are never both high for one key.
- Position index (oPOS updates on the edge after the oPRESS cycle, i.e. 1-cycle latency):
  - oPRESS[0] alone: oPOS+1, with 7 wrapping to 0.
  - oPRESS[1] alone: oPOS-1, with 0 wrapping to 7.
  - oPRESS[0] and oPRESS[1] in the same cycle: no change.
  - Other keys and release pulses do not affect oPOS.
- Keys are independent; simultaneous transitions on different keys are each handled normally.
- Debounce counter width: the minimum needed to hold STABLE_CNT-1. No counter overflow is possible.

Test Plan:
All directed tests use DIV_W=2 (tick every 4 cycles) and STABLE_CNT=3.
1. Reset and prescaler: hold iRST_N=0 for 5 cycles with iKEY=4'hF, then release. All outputs stay 0 during reset. oTICK first pulses on cycle 4 after release, then every 4 cycles. oKEY stays 0 until the debounce completes.
2. Clean press: after reset, set iKEY[0]=1 and hold. oKEY[0] rises 10–15 cycles later, with a single oPRESS[0] pulse in that cycle. oPOS changes 0->1 on the next cycle. Then release iKEY[0]: oKEY[0] falls in the same latency window with a single oRELEASE[0] pulse, and oPOS stays 1.
3. Bounce rejection: toggle iKEY[2] with pattern 1,1,1,1,0,0,0,0 repeating (high for 4 cycles, low for 4) for 60 cycles. oKEY[2] stays 0 and no pulses occur. Then hold 1: oKEY[2] rises within 15 cycles.
4. Wrap: issue 8 clean presses on key 0, confirming oPOS steps 1..7 then 0. Issue 1 press on key 1 from 0: oPOS becomes 7.
5. Simultaneous: assert iKEY[0] and iKEY[1] on the same cycle and hold. Both oPRESS pulses land in the same cycle, and oPOS is unchanged.
6. Reset mid-operation: with oPOS=5 and iKEY[1] held for 9 cycles (debounce in progress), assert iRST_N=0 for 1 cycle. All outputs become 0 on that edge. With iKEY[1] still held after release, a fresh full debounce (10–15 cycles) is required before oPRESS[1]; oPOS then becomes 7.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, tick-gated debounce per key,
// single-cycle press/release pulses and a 3-bit up/down position index.
module key_debounce #(
    parameter int N_KEYS     = 4,
    parameter int DIV_W      = 19,
    parameter int STABLE_CNT = 4
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [N_KEYS-1:0] iKEY,
    output logic [N_KEYS-1:0] oKEY,
    output logic [N_KEYS-1:0] oPRESS,
    output logic [N_KEYS-1:0] oRELEASE,
    output logic [2:0]        oPOS,
    output logic              oTICK
);

    localparam int CNT_W = $clog2(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    // oTICK is registered, so it is raised one count early to coincide with all-ones.
    localparam logic [DIV_W-1:0] TICK_PRE = ~DIV_W'(1);

    logic [N_KEYS-1:0] sync_a;
    logic [N_KEYS-1:0] sync_b;
    logic [DIV_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  deb_cnt [N_KEYS];

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            sync_a  <= '0;
            sync_b  <= '0;
            div_cnt <= '0;
            oTICK   <= 1'b0;
        end else begin
            sync_a  <= iKEY;
            sync_b  <= sync_a;
            div_cnt <= div_cnt + DIV_W'(1);
            oTICK   <= (div_cnt == TICK_PRE);
        end
    end

    // A key level is accepted only after STABLE_CNT consecutive disagreeing ticks.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            oKEY     <= '0;
            oPRESS   <= '0;
            oRELEASE <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                deb_cnt[k] <= '0;
            end
        end else begin
            oPRESS   <= '0;
            oRELEASE <= '0;
            if (oTICK) begin
                for (int k = 0; k < N_KEYS; k++) begin
                    if (sync_b[k] == oKEY[k]) begin
                        deb_cnt[k] <= '0;
                    end else if (deb_cnt[k] == CNT_LAST) begin
                        oKEY[k]     <= sync_b[k];
                        oPRESS[k]   <= sync_b[k];
                        oRELEASE[k] <= ~sync_b[k];
                        deb_cnt[k]  <= '0;
                    end else begin
                        deb_cnt[k] <= deb_cnt[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Opposing presses in the same cycle cancel out.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            oPOS <= '0;
        end else if (oPRESS[0] && !oPRESS[1]) begin
            oPOS <= oPOS + 3'd1;
        end else if (oPRESS[1] && !oPRESS[0]) begin
            oPOS <= oPOS - 3'd1;
        end
    end

endmodule
